// File: rtl/uart_memif_poller_if.sv
// CCX memory interface between a requester and the fabric.
// Requester drives the request; the fabric answers with gnt, rdata and error.
interface scarv_ccx_memif;
   logic        req;
   logic        gnt;
   logic        wen;
   logic [3:0]  strb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        error;

   modport REQ (
      output req, wen, strb, addr, wdata,
      input  gnt, rdata, error
   );

   modport RSP (
      input  req, wen, strb, addr, wdata,
      output gnt, rdata, error
   );
endinterface

// File: rtl/uart_memif_poller.sv
// UART register-window poller acting as a CCX requester.
// Streams TX bytes into the UART and RX bytes out, counting bus errors.
module uart_memif_poller #(
   parameter logic [31:0] UART_BASE = 32'h4000_1000,
   parameter int unsigned POLL_GAP  = 16
) (
   input  logic        g_clk,
   input  logic        g_reset,
   output logic        g_clk_req,
   input  logic        en,
   scarv_ccx_memif.REQ memif,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [7:0]  tx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [7:0]  rx_data,
   output logic [7:0]  err_cnt
);

   localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP - 1);

   typedef enum logic [2:0] {
      IDLE, STAT_REQ, STAT_RSP, RX_REQ,
      RX_RSP, TX_REQ, TX_RSP, WAIT
   } state_t;

   state_t state;
   state_t next_state;

   logic [GAP_W-1:0] gap_cnt;
   logic             tx_hold_valid;
   logic [7:0]       tx_hold;
   logic             rx_out_valid;

   logic        req_q, wen_q;
   logic [3:0]  strb_q;
   logic [31:0] addr_q, wdata_q;
   logic        req_d, wen_d;
   logic [3:0]  strb_d;
   logic [31:0] addr_d, wdata_d;

   logic accept;
   logic rx_avail;
   logic tx_full;
   logic in_rsp;
   logic unused_rdata;

   assign accept       = req_q && memif.gnt;
   assign rx_avail     = memif.rdata[0];
   assign tx_full      = memif.rdata[3];
   assign in_rsp       = (state == STAT_RSP) || (state == RX_RSP) ||
                         (state == TX_RSP);
   assign unused_rdata = ^memif.rdata[31:8];

   assign memif.req   = req_q;
   assign memif.wen   = wen_q;
   assign memif.strb  = strb_q;
   assign memif.addr  = addr_q;
   assign memif.wdata = wdata_q;

   assign tx_ready  = !tx_hold_valid;
   assign rx_valid  = rx_out_valid;
   assign g_clk_req = en || (state != IDLE) || tx_hold_valid || rx_out_valid;

   // FSM state register
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) state <= IDLE;
      else         state <= next_state;
   end

   // FSM next-state: RX is served before TX to limit UART overrun
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:     if (en) next_state = STAT_REQ;
         STAT_REQ: if (accept) next_state = STAT_RSP;
         STAT_RSP: begin
            if (memif.error)
               next_state = WAIT;
            else if (rx_avail && !rx_out_valid)
               next_state = RX_REQ;
            else if (tx_hold_valid && !tx_full)
               next_state = TX_REQ;
            else
               next_state = WAIT;
         end
         RX_REQ:   if (accept) next_state = RX_RSP;
         RX_RSP:   next_state = STAT_REQ;
         TX_REQ:   if (accept) next_state = TX_RSP;
         TX_RSP:   next_state = WAIT;
         WAIT: begin
            if (gap_cnt == '0)
               next_state = en ? STAT_REQ : IDLE;
         end
         default:  next_state = IDLE;
      endcase
   end

   // FSM outputs: request fields for the state being entered
   always_comb begin
      req_d   = 1'b0;
      wen_d   = wen_q;
      strb_d  = strb_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (next_state)
         STAT_REQ: begin
            req_d  = 1'b1;
            wen_d  = 1'b0;
            strb_d = 4'hF;
            addr_d = UART_BASE + 32'h8;
         end
         RX_REQ: begin
            req_d  = 1'b1;
            wen_d  = 1'b0;
            strb_d = 4'hF;
            addr_d = UART_BASE;
         end
         TX_REQ: begin
            req_d   = 1'b1;
            wen_d   = 1'b1;
            strb_d  = 4'b0001;
            addr_d  = UART_BASE + 32'h4;
            wdata_d = {24'b0, tx_hold};
         end
         default: ;
      endcase
   end

   // Registered request outputs, held stable while stalled
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         req_q   <= 1'b0;
         wen_q   <= 1'b0;
         strb_q  <= 4'h0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
      end else begin
         req_q   <= req_d;
         wen_q   <= wen_d;
         strb_q  <= strb_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // TX holding register: errored writes keep the byte for retry
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         tx_hold_valid <= 1'b0;
         tx_hold       <= 8'h0;
      end else if (state == TX_RSP) begin
         if (!memif.error) tx_hold_valid <= 1'b0;
      end else if (tx_valid && tx_ready) begin
         tx_hold_valid <= 1'b1;
         tx_hold       <= tx_data;
      end
   end

   // RX output register: errored reads are dropped
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         rx_out_valid <= 1'b0;
         rx_data      <= 8'h0;
      end else if (state == RX_RSP && !memif.error) begin
         rx_out_valid <= 1'b1;
         rx_data      <= memif.rdata[7:0];
      end else if (rx_valid && rx_ready) begin
         rx_out_valid <= 1'b0;
      end
   end

   // Saturating bus error counter
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset)
         err_cnt <= 8'h0;
      else if (in_rsp && memif.error && err_cnt != 8'hFF)
         err_cnt <= err_cnt + 8'h1;
   end

   // Poll gap counter, reloaded on every entry to WAIT
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset)
         gap_cnt <= '0;
      else if (next_state == WAIT && state != WAIT)
         gap_cnt <= GAP_LOAD;
      else if (state == WAIT && gap_cnt != '0)
         gap_cnt <= gap_cnt - 1'b1;
   end

endmodule

// File: tb/tb_uart_memif_poller.sv
// Bench for uart_memif_poller: fabric slave with a UART model and
// transaction-level scoreboard for the TX and RX byte streams.
module tb_uart_memif_poller;

   localparam logic [31:0] BASE = 32'h4000_1000;
   localparam int PG = 4;

   logic       g_clk = 1'b0;
   logic       g_reset;
   logic       g_clk_req;
   logic       en;
   logic       tx_valid, tx_ready;
   logic [7:0] tx_data;
   logic       rx_valid, rx_ready;
   logic [7:0] rx_data;
   logic [7:0] err_cnt;

   scarv_ccx_memif bus ();

   uart_memif_poller #(.UART_BASE(BASE), .POLL_GAP(PG)) dut (
      .g_clk     (g_clk),
      .g_reset   (g_reset),
      .g_clk_req (g_clk_req),
      .en        (en),
      .memif     (bus),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .err_cnt   (err_cnt)
   );

   always #5 g_clk = ~g_clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // UART and stream model
   logic [7:0] exp_tx[$];
   logic [7:0] exp_rx[$];
   logic [7:0] uart_rx[$];
   int         kinds[$];

   int gnt_mode = 0;
   int err_pct = 0;
   int force_err = 0;
   bit err_wr_once = 0;
   int full_polls = 0;
   bit full_rand = 0;
   bit rdy_rand = 0;
   bit chk_gap = 0;
   bit lat_arm = 0;
   bit lat_have = 0;
   int lat_stat = 0;

   int cyc = 0, n_stat = 0, n_wr = 0, n_rd = 0, n_txn = 0, n_err = 0;
   bit req_seen = 0;
   int last_stat_cyc = 0;
   int prev_kind = 0;
   bit prev_err = 0;
   logic [7:0] prev_stat = 8'h0;
   bit pend = 0;
   bit pend_err = 0;
   logic [31:0] pend_rdata = 32'h0;
   bit prev_stall = 0, prev_acc = 0, prev_rxv = 0;
   logic [31:0] h_addr, h_wdata;
   logic [3:0]  h_strb;
   logic        h_wen;

   function automatic int cnt_of(input int w);
      case (w)
         0: return n_wr;
         1: return n_stat;
         default: return n_txn;
      endcase
   endfunction

   function automatic int kind_at(input int i);
      if (i < kinds.size()) return kinds[i];
      return -1;
   endfunction

   task automatic accept();
      bit e;
      int kind;
      logic [31:0] r;
      logic [7:0] st, b;
      e = 0;
      kind = 0;
      st = 8'h0;
      r = $urandom;
      n_txn++;
      if (force_err > 0) begin
         e = 1;
         force_err--;
      end else if (err_wr_once && bus.wen) begin
         e = 1;
         err_wr_once = 0;
      end else if (int'($urandom % 100) < err_pct) begin
         e = 1;
      end
      if (e) n_err++;
      if (!bus.wen && bus.addr == BASE + 32'h8) begin
         kind = 1;
         chk("stat_strb", bus.strb, 4'hF);
         if (chk_gap && prev_kind == 1)
            chk("poll_gap", cyc - last_stat_cyc, PG + 2);
         st[0] = uart_rx.size() > 0;
         st[3] = (full_polls > 0) || (full_rand && ($urandom % 3 == 0));
         if (full_polls > 0) full_polls--;
         r[0] = st[0];
         r[3] = st[3];
         n_stat++;
         last_stat_cyc = cyc;
      end else if (!bus.wen && bus.addr == BASE) begin
         kind = 2;
         chk("rx_strb", bus.strb, 4'hF);
         chk("rx_after_stat", {prev_kind == 1, !prev_err, prev_stat[0]},
             3'b111);
         b = uart_rx.size() > 0 ? uart_rx.pop_front() : r[15:8];
         r[7:0] = b;
         if (!e) exp_rx.push_back(b);
         if (lat_arm) begin
            lat_stat = last_stat_cyc;
            lat_have = 1;
         end
         n_rd++;
      end else if (bus.wen && bus.addr == BASE + 32'h4) begin
         kind = 3;
         chk("wr_strb", bus.strb, 4'b0001);
         chk("wr_after_stat", {prev_kind == 1, !prev_err, !prev_stat[3]},
             3'b111);
         if (exp_tx.size() == 0) begin
            chk("wr_extra", exp_tx.size(), 1);
         end else begin
            chk("wr_data", bus.wdata, {24'h0, exp_tx[0]});
            if (!e) void'(exp_tx.pop_front());
         end
         n_wr++;
      end else begin
         chk("addr_bad", bus.addr, BASE + 32'h8);
      end
      if (prev_kind == 2) chk("stat_after_rx", kind, 1);
      kinds.push_back(kind);
      pend = 1;
      pend_err = e;
      pend_rdata = r;
      prev_kind = kind;
      prev_err = e;
      if (kind == 1) prev_stat = st;
   endtask

   // Fabric slave, protocol monitor and RX consumer, all on negedge
   initial begin
      bit g;
      bus.gnt = 1'b0;
      bus.rdata = 32'h0;
      bus.error = 1'b0;
      forever begin
         @(negedge g_clk);
         cyc++;
         if (g_reset) begin
            pend = 0;
            prev_stall = 0;
            prev_acc = 0;
            prev_kind = 0;
            prev_rxv = 0;
            bus.gnt = 1'b0;
            bus.error = 1'b0;
            bus.rdata = 32'h0;
            continue;
         end
         bus.error = pend ? pend_err : 1'b0;
         bus.rdata = pend ? pend_rdata : $urandom;
         pend = 0;
         if (bus.req) req_seen = 1;
         if (prev_acc) chk("req_drop", bus.req, 0);
         if (prev_stall) begin
            chk("hold_req", bus.req, 1);
            chk("hold_addr", bus.addr, h_addr);
            chk("hold_wdata", bus.wdata, h_wdata);
            chk("hold_ctl", {bus.wen, bus.strb}, {h_wen, h_strb});
         end
         case (gnt_mode)
            0: g = 1;
            1: g = ($urandom % 100) < 60;
            default: g = 0;
         endcase
         bus.gnt = g;
         prev_stall = bus.req && !g;
         prev_acc = bus.req && g;
         h_addr = bus.addr;
         h_wdata = bus.wdata;
         h_wen = bus.wen;
         h_strb = bus.strb;
         if (bus.req && g) accept();
         if (rdy_rand) rx_ready = $urandom % 2;
         if (rx_valid && !prev_rxv && lat_arm && lat_have) begin
            chk("rx_lat", cyc - lat_stat, 4);
            lat_arm = 0;
         end
         prev_rxv = rx_valid;
         if (rx_valid && rx_ready) begin
            if (exp_rx.size() == 0) chk("rx_extra", exp_rx.size(), 1);
            else chk("rx_data", rx_data, exp_rx.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge g_clk);
      #1;
   endtask

   task automatic push_tx(input logic [7:0] b);
      int t;
      t = 0;
      while (!tx_ready && t < 500) begin
         tick(1);
         t++;
      end
      if (!tx_ready) chk("tx_ready_wait", tx_ready, 1);
      tx_valid = 1'b1;
      tx_data = b;
      exp_tx.push_back(b);
      tick(1);
      tx_valid = 1'b0;
   endtask

   task automatic wait_for(input string tag, input int w, input int target,
                           input int budget);
      int t;
      t = 0;
      while (cnt_of(w) < target && t < budget) begin
         tick(1);
         t++;
      end
      if (cnt_of(w) < target) chk(tag, cnt_of(w), target);
   endtask

   initial begin
      int base, mark, rb, t;
      g_reset = 1'b1;
      en = 1'b0;
      tx_valid = 1'b0;
      tx_data = 8'h0;
      rx_ready = 1'b1;
      tick(3);
      chk("rst_req", bus.req, 0);
      chk("rst_fields", {bus.wen, bus.strb}, 5'h0);
      chk("rst_addr", bus.addr, 0);
      chk("rst_wdata", bus.wdata, 0);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx", {rx_valid, rx_data}, 9'h0);
      chk("rst_err", err_cnt, 0);
      chk("rst_clk_req", g_clk_req, 0);
      @(posedge g_clk);
      #2 g_reset = 1'b0;

      // idle with en low
      tick(20);
      chk("idle_req", req_seen, 0);
      chk("idle_clk_req", g_clk_req, 0);
      chk("idle_tx_ready", tx_ready, 1);

      // single TX, loaded while disabled
      push_tx(8'h41);
      chk("hold_clk_req", g_clk_req, 1);
      chk("hold_tx_busy", tx_ready, 0);
      chk("dis_no_req", req_seen, 0);
      en = 1'b1;
      wait_for("tx1_timeout", 0, 1, 100);
      tick(3);
      chk("tx1_ready", tx_ready, 1);
      chk("tx1_count", n_wr, 1);

      // TX blocked by tx_full for three polls
      chk_gap = 1;
      full_polls = 3;
      base = n_stat;
      push_tx(8'h42);
      wait_for("tx2_timeout", 0, 2, 200);
      chk("blk_polls", n_stat - base, 4);
      chk_gap = 0;

      // disable and let the FSM retire to IDLE
      en = 1'b0;
      tick(20);
      chk("retire_clk_req", g_clk_req, 0);

      // RX priority over a pending TX, then backpressure
      rx_ready = 1'b0;
      push_tx(8'h43);
      uart_rx.push_back(8'h5A);
      lat_arm = 1;
      lat_have = 0;
      mark = n_txn;
      en = 1'b1;
      wait_for("prio_timeout", 0, 3, 100);
      chk("prio_k0", kind_at(mark), 1);
      chk("prio_k1", kind_at(mark + 1), 2);
      chk("prio_k2", kind_at(mark + 2), 1);
      chk("prio_k3", kind_at(mark + 3), 3);
      chk("rx_hold_v", rx_valid, 1);
      chk("rx_hold_d", rx_data, 8'h5A);
      uart_rx.push_back(8'h66);
      rb = n_rd;
      wait_for("bp_timeout", 1, n_stat + 3, 100);
      chk("bp_no_read", n_rd, rb);
      chk("bp_data", rx_data, 8'h5A);
      rx_ready = 1'b1;
      t = 0;
      while ((exp_rx.size() + uart_rx.size() != 0 || rx_valid) && t < 200) begin
         tick(1);
         t++;
      end
      chk("rx_drain", exp_rx.size() + uart_rx.size() + rx_valid, 0);

      // error on a TX write, retried on the next poll
      base = n_wr;
      err_wr_once = 1;
      push_tx(8'h44);
      wait_for("retry_timeout", 0, base + 2, 200);
      tick(2);
      chk("err_one", err_cnt, 1);
      chk("retry_ready", tx_ready, 1);
      chk("retry_left", exp_tx.size(), 0);

      // saturation
      force_err = 300;
      t = 0;
      while (force_err > 0 && t < 4000) begin
         tick(1);
         t++;
      end
      tick(3);
      chk("err_sat", err_cnt, 8'hFF);

      // async reset while a request is stalled
      gnt_mode = 2;
      push_tx(8'h55);
      t = 0;
      while (!bus.req && t < 50) begin
         tick(1);
         t++;
      end
      chk("stall_req", bus.req, 1);
      #1 g_reset = 1'b1;
      #1;
      chk("arst_req", bus.req, 0);
      chk("arst_err", err_cnt, 0);
      chk("arst_tx_ready", tx_ready, 1);
      exp_tx.delete();
      exp_rx.delete();
      n_err = 0;
      @(posedge g_clk);
      #2 g_reset = 1'b0;
      gnt_mode = 0;
      mark = n_txn;
      wait_for("arst_timeout", 2, mark + 1, 50);
      chk("arst_first", kind_at(mark), 1);

      // randomized traffic
      err_pct = 10;
      gnt_mode = 1;
      rdy_rand = 1;
      full_rand = 1;
      for (int i = 0; i < 60; i++) begin
         case ($urandom % 4)
            0: push_tx(8'($urandom));
            1: if (uart_rx.size() < 4) uart_rx.push_back(8'($urandom));
            2: if ($urandom % 5 == 0) en = ~en;
            default: ;
         endcase
         tick($urandom_range(1, 8));
      end
      err_pct = 0;
      full_rand = 0;
      rdy_rand = 0;
      en = 1'b1;
      tick(1);
      rx_ready = 1'b1;
      t = 0;
      while ((exp_tx.size() + exp_rx.size() + uart_rx.size() != 0 ||
              !tx_ready || rx_valid) && t < 3000) begin
         tick(1);
         t++;
      end
      chk("rand_drain", exp_tx.size() + exp_rx.size() + uart_rx.size(), 0);
      chk("rand_idle", {tx_ready, rx_valid}, 2'b10);
      chk("rand_err", err_cnt, (n_err > 255) ? 255 : n_err);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
